// File: rtl/mo_mul_pipe.sv
// Flow-controlled pipelined Montgomery multiplier: out_result = a*b*2^-WIDTH mod Q, tag carried alongside.
// Define MO_MUL_FULL_REDUCE_EN for an extra conditional-subtract stage (full range for any a < 2^WIDTH).
module mo_mul_pipe #(
  parameter int WIDTH      = 12,
  parameter int Q          = 3329,
  parameter int Q_M        = 8,
  parameter int Q_K        = 13,
  parameter int STAGE_BITS = 1,
  parameter int TAG_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);
  localparam int NSTG = WIDTH / STAGE_BITS;
  localparam int DW   = WIDTH + 1;
  localparam int TW   = WIDTH + 2;
  localparam logic [TW-1:0]    QM1 = TW'(Q_K) << Q_M;
  localparam logic [WIDTH-1:0] Q_W = WIDTH'(Q);

  // On odd t, subtracting Q-1 then dropping the low bit equals (t - Q) / 2.
  function automatic logic [DW-1:0] red_step(input logic [DW-1:0] d,
                                             input logic [WIDTH-1:0] a,
                                             input logic bk);
    logic [TW-1:0] t;
    t = {d[DW-1], d} + (bk ? {2'b00, a} : '0);
    if (t[0]) t = t - QM1;
    return t[DW:1];
  endfunction

  logic [NSTG-1:0]  v_q, v_d;
  logic [DW-1:0]    d_q [NSTG];
  logic [DW-1:0]    d_d [NSTG];
  logic [WIDTH-1:0] a_q [NSTG];
  logic [WIDTH-1:0] a_d [NSTG];
  logic [WIDTH-1:0] b_q [NSTG];
  logic [WIDTH-1:0] b_d [NSTG];
  logic [TAG_W-1:0] t_q [NSTG];
  logic [TAG_W-1:0] t_d [NSTG];

  logic             s_v;
  logic [DW-1:0]    s_d;
  logic [WIDTH-1:0] s_a, s_b;
  logic [TAG_W-1:0] s_t;

  logic             stall;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic [TAG_W-1:0] out_tag_q;

  logic [WIDTH-1:0] corr_res;
  logic             fin_valid;
  logic [WIDTH-1:0] fin_res;
  logic [TAG_W-1:0] fin_tag;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  // b is shifted right as it travels, so every stage consumes its low bits.
  always_comb begin
    s_v = in_valid;
    s_d = '0;
    s_a = in_a;
    s_b = in_b;
    s_t = in_tag;
    for (int i = 0; i < NSTG; i++) begin
      for (int j = 0; j < STAGE_BITS; j++) begin
        s_d = red_step(s_d, s_a, s_b[0]);
        s_b = s_b >> 1;
      end
      v_d[i] = s_v;
      d_d[i] = s_d;
      a_d[i] = s_a;
      b_d[i] = s_b;
      t_d[i] = s_t;
      s_v = v_q[i];
      s_d = d_q[i];
      s_a = a_q[i];
      s_b = b_q[i];
      s_t = t_q[i];
    end
  end

  assign corr_res = d_q[NSTG-1][WIDTH-1:0] + (d_q[NSTG-1][DW-1] ? Q_W : '0);

`ifdef MO_MUL_FULL_REDUCE_EN
  logic             c_valid_q;
  logic [WIDTH-1:0] c_res_q;
  logic [TAG_W-1:0] c_tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid_q <= 1'b0;
      c_res_q   <= '0;
      c_tag_q   <= '0;
    end else if (!stall) begin
      c_valid_q <= v_q[NSTG-1];
      c_res_q   <= corr_res;
      c_tag_q   <= t_q[NSTG-1];
    end
  end

  assign fin_valid = c_valid_q;
  assign fin_res   = (c_res_q >= Q_W) ? c_res_q - Q_W : c_res_q;
  assign fin_tag   = c_tag_q;
`else
  assign fin_valid = v_q[NSTG-1];
  assign fin_res   = corr_res;
  assign fin_tag   = t_q[NSTG-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q          <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      for (int i = 0; i < NSTG; i++) begin
        d_q[i] <= '0;
        a_q[i] <= '0;
        b_q[i] <= '0;
        t_q[i] <= '0;
      end
    end else if (!stall) begin
      v_q          <= v_d;
      out_valid_q  <= fin_valid;
      out_result_q <= fin_res;
      out_tag_q    <= fin_tag;
      for (int i = 0; i < NSTG; i++) begin
        d_q[i] <= d_d[i];
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
        t_q[i] <= t_d[i];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
endmodule
